simon_seq_engine: RTL and testbench

Parameterised Simon-style game sequencer. It generates a pseudo-random colour sequence, plays it back one step per timed interval, then checks user key presses against it, growing the sequence by one each round. It sits between the KEY/SW input logic and the display_grid / 7-segment status logic. Its 2-bit state output keeps the existing encoding: 00 ready, 01 game, 10 user, 11 over.

---
 rtl/simon_seq_engine_if.sv | 30 +++
 rtl/simon_seq_engine.sv | 201 ++++++++++++++++++++
 tb/tb_simon_seq_engine.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_seq_engine_if.sv
// Control/status bundle between KEY/SW input logic and the Simon engine.
// master: input side that drives start/level/keys; slave: the engine.
interface simon_seq_engine_if #(
    parameter int NUM_COLORS = 4,
    parameter int MAX_LEN    = 16
);
    localparam int CW = $clog2(NUM_COLORS);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          start;
    logic [2:0]    level;
    logic          key_valid;
    logic [CW-1:0] key_color;
    logic          show_valid;
    logic [CW-1:0] show_color;
    logic [1:0]    state;
    logic [LW-1:0] round;
    logic          win;
    logic          lose;

    modport master (
        output start, level, key_valid, key_color,
        input  show_valid, show_color, state, round, win, lose
    );

    modport slave (
        input  start, level, key_valid, key_color,
        output show_valid, show_color, state, round, win, lose
    );
endinterface

// File: rtl/simon_seq_engine.sv
// Simon game sequencer: LFSR colour source, timed playback, key checking.
// Define SIMON_TIMEOUT_EN to lose after 4 idle step lengths in USER.
module simon_seq_engine #(
    parameter int          NUM_COLORS     = 4,
    parameter int          MAX_LEN        = 16,
    parameter int          TICKS_PER_STEP = 25000000,
    parameter int          GAP_TICKS      = 5000000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input logic               CLOCK_50,
    input logic               reset,
    simon_seq_engine_if.slave bus
);
    localparam int CW = $clog2(NUM_COLORS);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TICKS_PER_STEP + GAP_TICKS + 1) + 2;

    typedef enum logic [2:0] {
        S_READY,
        S_ADD,
        S_PLAY,
        S_USER,
        S_OVER
    } fsm_e;

    fsm_e          fsm_q;
    logic [15:0]   lfsr_q;
    logic [CW-1:0] seq_q [MAX_LEN];
    logic [LW-1:0] round_q;
    logic [LW-1:0] idx_q;
    logic [TW-1:0] cnt_q;
    logic          gap_q;
    logic [1:0]    state_q;
    logic          show_v_q;
    logic [CW-1:0] show_c_q;
    logic          win_q;
    logic          lose_q;
`ifdef SIMON_TIMEOUT_EN
    logic [TW-1:0] tmo_q;
`endif

    logic [2:0]    lvl_eff;
    logic [TW-1:0] step_len;
    logic [CW-1:0] elem;
    logic          key_ok;
    logic          key_hit;
    logic          key_last;
    logic          seq_we;
    logic [IW-1:0] seq_wa;

    // Faster levels halve the step; never let it collapse to zero.
    always_comb begin
        lvl_eff = bus.level;
        if (bus.level == 3'd0) lvl_eff = 3'd1;
        else if (bus.level > 3'd5) lvl_eff = 3'd5;
        step_len = TW'(TICKS_PER_STEP) >> (lvl_eff - 3'd1);
        if (step_len == '0) step_len = TW'(1);
    end

    assign elem     = CW'(int'(lfsr_q[CW-1:0]) % NUM_COLORS);
    assign key_ok   = bus.key_valid && (int'(bus.key_color) < NUM_COLORS);
    assign key_hit  = (bus.key_color == seq_q[IW'(idx_q)]);
    assign key_last = (idx_q == round_q - LW'(1));

    always_comb begin
        seq_we = 1'b0;
        seq_wa = IW'(round_q);
        unique case (fsm_q)
            S_READY, S_OVER: begin
                seq_we = bus.start;
                seq_wa = '0;
            end
            S_USER: seq_we = key_ok && key_hit && key_last
                             && (round_q != LW'(MAX_LEN));
            default: ;
        endcase
    end

    // Sequence storage is deliberately not reset.
    always_ff @(posedge CLOCK_50) begin
        if (seq_we) seq_q[seq_wa] <= elem;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fsm_q    <= S_READY;
            lfsr_q   <= LFSR_SEED;
            round_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            gap_q    <= 1'b0;
            state_q  <= 2'b00;
            show_v_q <= 1'b0;
            show_c_q <= '0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            lfsr_q <= {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            unique case (fsm_q)
                S_READY: begin
                    if (bus.start) begin
                        fsm_q   <= S_ADD;
                        state_q <= 2'b01;
                        round_q <= LW'(1);
                    end
                end
                S_ADD: begin
                    fsm_q    <= S_PLAY;
                    idx_q    <= '0;
                    gap_q    <= 1'b0;
                    cnt_q    <= step_len - TW'(1);
                    show_v_q <= 1'b1;
                    show_c_q <= seq_q[0];
                end
                S_PLAY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - TW'(1);
                    end else if (!gap_q) begin
                        gap_q    <= 1'b1;
                        cnt_q    <= TW'(GAP_TICKS - 1);
                        show_v_q <= 1'b0;
                        show_c_q <= '0;
                    end else if (key_last) begin
                        fsm_q   <= S_USER;
                        state_q <= 2'b10;
                        idx_q   <= '0;
`ifdef SIMON_TIMEOUT_EN
                        tmo_q   <= (step_len << 2) - TW'(1);
`endif
                    end else begin
                        idx_q    <= idx_q + LW'(1);
                        gap_q    <= 1'b0;
                        cnt_q    <= step_len - TW'(1);
                        show_v_q <= 1'b1;
                        show_c_q <= seq_q[IW'(idx_q + LW'(1))];
                    end
                end
                S_USER: begin
                    show_v_q <= 1'b0;
                    show_c_q <= '0;
                    if (key_ok) begin
                        if (!key_hit) begin
                            fsm_q   <= S_OVER;
                            state_q <= 2'b11;
                            lose_q  <= 1'b1;
                        end else if (!key_last) begin
                            idx_q    <= idx_q + LW'(1);
                            show_v_q <= 1'b1;
                            show_c_q <= bus.key_color;
`ifdef SIMON_TIMEOUT_EN
                            tmo_q    <= (step_len << 2) - TW'(1);
`endif
                        end else if (round_q == LW'(MAX_LEN)) begin
                            fsm_q   <= S_OVER;
                            state_q <= 2'b11;
                            win_q   <= 1'b1;
                        end else begin
                            fsm_q   <= S_ADD;
                            state_q <= 2'b01;
                            round_q <= round_q + LW'(1);
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (tmo_q == '0) begin
                        fsm_q   <= S_OVER;
                        state_q <= 2'b11;
                        lose_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
                    end
`endif
                end
                S_OVER: begin
                    if (bus.start) begin
                        fsm_q   <= S_ADD;
                        state_q <= 2'b01;
                        round_q <= LW'(1);
                        win_q   <= 1'b0;
                        lose_q  <= 1'b0;
                    end
                end
                default: begin
                    fsm_q   <= S_READY;
                    state_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.show_valid = show_v_q;
    assign bus.show_color = show_c_q;
    assign bus.state      = state_q;
    assign bus.round      = round_q;
    assign bus.win        = win_q;
    assign bus.lose       = lose_q;
endmodule

// File: tb/tb_simon_seq_engine.sv
// Scoreboard bench for simon_seq_engine: expected output changes are queued
// with their cycle stamps and matched by an independent monitor.
module tb_simon_seq_engine;
    localparam int          NC   = 4;
    localparam int          ML   = 3;
    localparam int          TPS  = 8;
    localparam int          GAP  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] rnd;
        logic       sv;
        logic [1:0] sc;
        logic       w;
        logic       l;
    } obs_t;

    typedef struct packed {
        int   cyc;
        obs_t o;
    } exp_t;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    simon_seq_engine_if #(.NUM_COLORS(NC), .MAX_LEN(ML)) bus ();

    simon_seq_engine #(
        .NUM_COLORS    (NC),
        .MAX_LEN       (ML),
        .TICKS_PER_STEP(TPS),
        .GAP_TICKS     (GAP),
        .LFSR_SEED     (SEED)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    exp_t        exp_q[$];
    int          cyc      = 0;
    int          n_chk    = 0;
    int          n_pass   = 0;
    int          snap_req = 0;
    int          snap_seen = 0;
    logic        mon_en   = 1'b0;
    logic        done_req = 1'b0;
    logic        done_ack = 1'b0;
    obs_t        prev;
    obs_t        cur;
    exp_t        e;
    logic [15:0] m;
    logic [1:0]  col [3];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Reference Fibonacci LFSR, taps 16,14,13,11.
    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) m <= SEED;
        else m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    function automatic obs_t mk(input logic [1:0] st, input logic [1:0] rnd,
                                input logic sv, input logic [1:0] sc,
                                input logic w, input logic l);
        mk = {st, rnd, sv, sc, w, l};
    endfunction

    always @(negedge CLOCK_50) begin
        cur = {bus.state, bus.round, bus.show_valid, bus.show_color,
               bus.win, bus.lose};
        if (mon_en && (cur != prev || snap_req != snap_seen)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d got st=%0d rnd=%0d sv=%0d sc=%0d w=%0d l=%0d, required no change",
                         cyc, cur.st, cur.rnd, cur.sv, cur.sc, cur.w, cur.l);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.o != cur)
                    $display("FAIL event got cyc=%0d st=%0d rnd=%0d sv=%0d sc=%0d w=%0d l=%0d, required cyc=%0d st=%0d rnd=%0d sv=%0d sc=%0d w=%0d l=%0d",
                             cyc, cur.st, cur.rnd, cur.sv, cur.sc, cur.w, cur.l,
                             e.cyc, e.o.st, e.o.rnd, e.o.sv, e.o.sc, e.o.w, e.o.l);
                else
                    n_pass++;
            end
        end
        snap_seen = snap_req;
        prev = cur;
        if (done_req && !done_ack) begin
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_chk++;
                $display("FAIL missing_event got none, required cyc=%0d st=%0d rnd=%0d sv=%0d",
                         e.cyc, e.o.st, e.o.rnd, e.o.sv);
            end
            done_ack = 1'b1;
        end
    end

    task automatic push(input int t, input obs_t o);
        exp_t x;
        x.cyc = t;
        x.o   = o;
        exp_q.push_back(x);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge CLOCK_50);
    endtask

    task automatic press(input logic [1:0] k);
        bus.key_valid = 1'b1;
        bus.key_color = k;
        @(negedge CLOCK_50);
        bus.key_valid = 1'b0;
    endtask

    // Force a comparison of the current outputs at the next sample.
    task automatic snap(input obs_t o);
        #1;
        push(cyc + 1, o);
        snap_req++;
        @(negedge CLOCK_50);
    endtask

    // s is the cycle the ADD state becomes visible.
    task automatic play(input int s, input int r, input int L, output int u);
        for (int i = 0; i < r; i++) begin
            push(s + 1 + i * (L + GAP), mk(2'b01, 2'(r), 1'b1, col[i], 1'b0, 1'b0));
            push(s + 1 + i * (L + GAP) + L, mk(2'b01, 2'(r), 1'b0, 2'd0, 1'b0, 1'b0));
        end
        u = s + 1 + r * (L + GAP);
        push(u, mk(2'b10, 2'(r), 1'b0, 2'd0, 1'b0, 1'b0));
    endtask

    // key_valid rides along with start; it must be ignored there.
    task automatic do_start(input logic [2:0] lv, input int L, output int u);
        int c;
        c = cyc;
        col[0] = m[1:0];
        push(c + 1, mk(2'b01, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0));
        play(c + 1, 1, L, u);
        bus.level     = lv;
        bus.start     = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_color = 2'd1;
        @(negedge CLOCK_50);
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
    endtask

    task automatic round_ok(input int r, input int u, input int L, output int u2);
        int c;
        u2 = 0;
        wait_to(u);
        for (int i = 0; i < r - 1; i++) begin
            c = cyc;
            push(c + 1, mk(2'b10, 2'(r), 1'b1, col[i], 1'b0, 1'b0));
            push(c + 2, mk(2'b10, 2'(r), 1'b0, 2'd0, 1'b0, 1'b0));
            press(col[i]);
            @(negedge CLOCK_50);
        end
        c = cyc;
        if (r < ML) begin
            col[r] = m[1:0];
            push(c + 1, mk(2'b01, 2'(r + 1), 1'b0, 2'd0, 1'b0, 1'b0));
            play(c + 1, r + 1, L, u2);
        end else begin
            push(c + 1, mk(2'b11, 2'(r), 1'b0, 2'd0, 1'b1, 1'b0));
        end
        press(col[r - 1]);
    endtask

    initial begin
        int u;
        int c;
        logic [1:0] bad;
        bus.start     = 1'b0;
        bus.level     = 3'd1;
        bus.key_valid = 1'b0;
        bus.key_color = 2'd0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        #1;
        mon_en = 1'b1;
        @(negedge CLOCK_50);
        snap(mk(2'b00, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        press(2'd2);
        repeat (18) @(negedge CLOCK_50);
        snap(mk(2'b00, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));

        // Game 1: level 1, clear round 1, miss in round 2.
        do_start(3'd1, 8, u);
        round_ok(1, u, 8, u);
        wait_to(u);
        bad = (col[0] == 2'd3) ? 2'd1 : 2'd3;
        c = cyc;
        push(c + 1, mk(2'b11, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1));
        press(bad);
        repeat (4) @(negedge CLOCK_50);
        press(col[0]);
        repeat (3) @(negedge CLOCK_50);

        // Game 2: level 7 acts as 5 (1-cycle steps), run to a win.
        do_start(3'd7, 1, u);
        round_ok(1, u, 1, u);
        round_ok(2, u, 1, u);
        round_ok(3, u, 1, u);
        repeat (4) @(negedge CLOCK_50);

        // Game 3: level 0 acts as 1, abandoned by reset mid-playback.
        c = cyc;
        col[0] = m[1:0];
        push(c + 1, mk(2'b01, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0));
        push(c + 2, mk(2'b01, 2'd1, 1'b1, col[0], 1'b0, 1'b0));
        bus.level = 3'd0;
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        wait_to(c + 4);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        push(c + 5, mk(2'b00, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        @(negedge CLOCK_50);
        repeat (2) @(negedge CLOCK_50);

        // Game 4: level 5, then sit idle in USER.
        do_start(3'd5, 1, u);
`ifdef SIMON_TIMEOUT_EN
        push(u + 4, mk(2'b11, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1));
        wait_to(u + 40);
        snap(mk(2'b11, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1));
`else
        wait_to(u + 40);
        snap(mk(2'b10, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0));
`endif

        done_req = 1'b1;
        for (int i = 0; i < 4 && !done_ack; i++) @(negedge CLOCK_50);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
